// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the data-memory arbiter: requester count, default
// memory size, the registered response record and the address-legality helper.
// ----------------------------------------------------------------------------
package cpu_pkg;

  // Two requesters: port 0 = CPU load/store, port 1 = debug/loader.
  localparam int NREQ_DEF      = 2;
  // Data memory size in bytes (1K 32-bit words).
  localparam int MEM_BYTES_DEF = 4096;
  // Width of the port id carried in the response record.
  localparam int PORT_W        = 1;

  // Response record registered one cycle after an accepted request.
  // The port id selects which rsp_valid bit pulses.
  typedef struct packed {
    logic              valid;
    logic [31:0]       rdata;
    logic              err;
    logic [PORT_W-1:0] port;
  } rsp_t;

  // An access is rejected when it is not word aligned or falls outside memory.
  function automatic logic addr_bad(input logic [31:0] a, input logic [31:0] limit);
    return (a[1:0] != 2'b00) || (a >= limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick. A lone requester always wins; under contention the
// port that was not granted last wins.
//   i_req  [1:0]  request vector
//   i_last        index of the most recently granted port
//   o_gnt  [1:0]  one-hot grant (zero when nothing requests)
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // Grant decode from the request pattern and the last-grant pointer.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates two requesters onto a single-ported data memory, one access per
// cycle, round-robin under contention. Misaligned or out-of-range accesses are
// accepted but never reach memory; they answer with rsp_err. Responses appear
// one cycle after acceptance with no backpressure.
//   clk, rst_n                  clock, async active-low reset
//   req/we [NREQ-1:0]           per-port request and write enable
//   addr/wdata [NREQ*32-1:0]    per-port byte address / write data, 32b lanes
//   gnt [NREQ-1:0]              combinational one-hot grant
//   rsp_valid/rsp_rdata/rsp_err registered response
//   mem_read/mem_write          combinational memory strobes
//   mem_address/mem_write_data  combinational memory address / write data
//   mem_read_data               combinational read data from memory
// ----------------------------------------------------------------------------
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*32-1:0] addr,
  input  logic [NREQ*32-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic        r_last;
  rsp_t        r_rsp;
  rsp_t        w_rsp_nxt;
  logic [1:0]  w_pick;
  logic [1:0]  w_gnt;
  logic        w_acc;
  logic        w_sel;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic        w_bad;

  rr_arb2 u_rr_arb2 (
    .i_req  (req[1:0]),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Grant is forced off while reset is asserted so nothing reaches memory.
  always_comb begin
    w_gnt = 2'b00;
    if (rst_n) begin
      w_gnt = w_pick;
    end else begin
      w_gnt = 2'b00;
    end
  end

  // Select the granted port's lane and classify the access.
  always_comb begin
    w_acc   = |w_gnt;
    w_sel   = w_gnt[1];
    w_addr  = w_sel ? addr[32 +: 32]  : addr[0 +: 32];
    w_wdata = w_sel ? wdata[32 +: 32] : wdata[0 +: 32];
    w_we    = w_sel ? we[1] : we[0];
    w_bad   = addr_bad(w_addr, MEM_LIMIT);
  end

  // Memory-side drive; the bus is quiet unless an access is accepted, and
  // rejected accesses keep both strobes low.
  always_comb begin
    gnt            = w_gnt;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'h0000_0000;
    mem_write_data = 32'h0000_0000;
    if (w_acc) begin
      mem_address    = w_addr;
      mem_write_data = w_wdata;
      mem_read       = !w_we && !w_bad;
      mem_write      =  w_we && !w_bad;
    end else begin
      mem_address    = 32'h0000_0000;
      mem_write_data = 32'h0000_0000;
    end
  end

  // Next response record: read data sampled in the accept cycle, zero for
  // writes and rejected accesses.
  always_comb begin
    w_rsp_nxt = '0;
    if (w_acc) begin
      w_rsp_nxt.valid = 1'b1;
      w_rsp_nxt.port  = w_sel;
      w_rsp_nxt.err   = w_bad;
      w_rsp_nxt.rdata = (!w_we && !w_bad) ? mem_read_data : 32'h0000_0000;
    end else begin
      w_rsp_nxt = '0;
    end
  end

  // Response register and last-grant pointer; pointer resets to 1 so port 0
  // wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp  <= '0;
      r_last <= 1'b1;
    end else begin
      r_rsp <= w_rsp_nxt;
      if (w_acc) begin
        r_last <= w_sel;
      end else begin
        r_last <= r_last;
      end
    end
  end

  // Expand the registered port id into the per-port valid pulse.
  always_comb begin
    rsp_valid = 2'b00;
    if (r_rsp.valid) begin
      rsp_valid[r_rsp.port] = 1'b1;
    end else begin
      rsp_valid = 2'b00;
    end
    rsp_rdata = r_rsp.rdata;
    rsp_err   = r_rsp.err;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.NREQ(2), .MEM_BYTES(4096)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .gnt            (gnt),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Memory attached to the DUT.
  logic [31:0] env_mem [1024];
  logic        env_ready = 1'b0;
  assign mem_read_data = env_mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= fill(i);
      env_ready <= 1'b1;
    end else if (mem_write) begin
      env_mem[mem_address[11:2]] <= mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: arbitration rule, address legality and a shadow
  // memory image, checked against the DUT every cycle.
  logic [31:0] ref_mem [1024];
  logic        m_ready = 1'b0;
  logic        m_ptr   = 1'b1;
  logic [1:0]  m_pv    = 2'b00;
  logic [31:0] m_pd    = 32'h0;
  logic        m_pe    = 1'b0;

  always @(negedge clk) begin : model
    logic [1:0]  eg;
    int          p;
    logic [31:0] a, d;
    logic        w, bd;
    if (!m_ready) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = fill(i);
      m_ready = 1'b1;
    end
    eg = 2'b00;
    if (!rst_n) begin
      m_ptr = 1'b1; m_pv = 2'b00; m_pd = 32'h0; m_pe = 1'b0;
    end else if (req == 2'b11) begin
      eg = m_ptr ? 2'b01 : 2'b10;
    end else begin
      eg = req;
    end
    chk("m_rsp_valid", {30'h0, rsp_valid}, {30'h0, m_pv});
    chk("m_rsp_rdata", rsp_rdata, m_pd);
    chk("m_rsp_err", {31'h0, rsp_err}, {31'h0, m_pe});
    chk("m_gnt", {30'h0, gnt}, {30'h0, eg});
    if (eg != 2'b00) begin
      p  = eg[1] ? 1 : 0;
      a  = addr[p*32 +: 32];
      d  = wdata[p*32 +: 32];
      w  = we[p];
      bd = (a % 4 != 0) || (a >= 32'd4096);
      chk("m_mem_read", {31'h0, mem_read}, {31'h0, !bd && !w});
      chk("m_mem_write", {31'h0, mem_write}, {31'h0, !bd && w});
      chk("m_mem_address", mem_address, a);
      chk("m_mem_wdata", mem_write_data, d);
      m_pv = eg;
      m_pe = bd;
      m_pd = (!bd && !w) ? ref_mem[a / 4] : 32'h0;
      if (!bd && w) ref_mem[a / 4] = d;
      m_ptr = eg[1];
    end else begin
      chk("m_idle_strobes", {30'h0, mem_read, mem_write}, 32'h0);
      chk("m_idle_address", mem_address, 32'h0);
      chk("m_idle_wdata", mem_write_data, 32'h0);
      m_pv = 2'b00; m_pd = 32'h0; m_pe = 1'b0;
    end
  end

  // Apply inputs just after a rising edge, return just after the falling edge.
  task automatic step(input logic [1:0] r, input logic [1:0] w,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk); #1;
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned s;
    s = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 63)) << 2;
    if (s == 0) a = a | 32'($urandom_range(1, 3));
    else if (s == 1) a = 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2);
    return a;
  endfunction

  initial begin
    int pulses;
    rst_n = 1'b0; req = 2'b11; we = 2'b00; addr = 64'h0; wdata = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_gnt", {30'h0, gnt}, 32'h0);
    chk("reset_mem_read", {31'h0, mem_read}, 32'h0);
    chk("reset_rsp_valid", {30'h0, rsp_valid}, 32'h0);

    // First read after reset.
    @(posedge clk); #1;
    rst_n = 1'b1; req = 2'b01; we = 2'b00; addr = {32'h0, 32'h0000_0010};
    @(negedge clk); #1;
    chk("rd_gnt", {30'h0, gnt}, 32'h1);
    chk("rd_mem_read", {31'h0, mem_read}, 32'h1);
    chk("rd_address", mem_address, 32'h0000_0010);
    step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rd_rsp_valid", {30'h0, rsp_valid}, 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", {31'h0, rsp_err}, 32'h0);

    // Continuous contention alternates starting at port 0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 2'b00, 32'h40, 32'h0, 32'h44, 32'h0);
      chk("rr_gnt", {30'h0, gnt}, (k % 2 == 1) ? 32'h2 : 32'h1);
      if (k > 0) chk("rr_rsp_valid", {30'h0, rsp_valid}, (k % 2 == 1) ? 32'h1 : 32'h2);
    end
    step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rr_last_rsp", {30'h0, rsp_valid}, 32'h2);

    // Write by port 1 then read by port 0.
    step(2'b10, 2'b10, 32'h0, 32'h0, 32'h20, 32'h1234_5678);
    chk("raw_mem_write", {31'h0, mem_write}, 32'h1);
    step(2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0);
    step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("raw_rsp_valid", {30'h0, rsp_valid}, 32'h1);
    chk("raw_rdata", rsp_rdata, 32'h1234_5678);

    // Misaligned read, then out-of-range write.
    step(2'b01, 2'b00, 32'h22, 32'h0, 32'h0, 32'h0);
    chk("err_strobes_a", {30'h0, mem_read, mem_write}, 32'h0);
    step(2'b10, 2'b10, 32'h0, 32'h0, 32'h1000, 32'hCAFE_F00D);
    chk("err_strobes_b", {30'h0, mem_read, mem_write}, 32'h0);
    chk("err_rsp_a", {rsp_rdata[29:0], rsp_valid}, 32'h1);
    chk("err_flag_a", {31'h0, rsp_err}, 32'h1);
    step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("err_rsp_b", {rsp_rdata[29:0], rsp_valid}, 32'h2);
    chk("err_rdata_b", rsp_rdata, 32'h0);
    chk("err_flag_b", {31'h0, rsp_err}, 32'h1);

    // Reset right after an accept suppresses the response and the pointer.
    step(2'b01, 2'b00, 32'h30, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 2'b11;
    #1;
    chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_gnt", {30'h0, gnt}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 2'b11; we = 2'b00; addr = {32'h44, 32'h40};
    @(negedge clk); #1;
    chk("rst_contention_gnt", {30'h0, gnt}, 32'h1);

    // Lone requester gets every cycle.
    step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(2'b01, 2'b00, 32'h100 + 32'(k * 4), 32'h0, 32'h0, 32'h0);
      chk("solo_gnt", {30'h0, gnt}, 32'h1);
      if (rsp_valid == 2'b01) pulses++;
    end
    step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    if (rsp_valid == 2'b01) pulses++;
    chk("solo_pulses", 32'(pulses), 32'd4);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      req   = 2'($urandom_range(0, 3));
      we    = 2'($urandom_range(0, 3));
      addr  = {rand_addr(), rand_addr()};
      wdata = {$urandom(), $urandom()};
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
